// File: rtl/fpaddsub_align_pipe_if.sv
// -----------------------------------------------------------------------------
// fpaddsub_align_pipe_if
// Handshake and data bundle for the FP add/sub alignment stage.
//   Input side : in_valid, in_ready, a, b, op
//   Output side: out_valid, out_ready, max_ab, c_exp, sign_max, eff_sub,
//                shift, m_max, m_min
// The slave modport is the alignment stage's view. The master modport is the
// view of the surrounding logic that feeds operands and consumes results.
// -----------------------------------------------------------------------------
interface fpaddsub_align_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRD_W = 3
);
  localparam int SW = MAN_W + 1 + GRD_W;
  localparam int DW = EXP_W + MAN_W + 1;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    a;
  logic [DW-1:0]    b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic             max_ab;
  logic [EXP_W-1:0] c_exp;
  logic             sign_max;
  logic             eff_sub;
  logic [EXP_W-1:0] shift;
  logic [SW-1:0]    m_max;
  logic [SW-1:0]    m_min;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, max_ab, c_exp, sign_max, eff_sub, shift,
           m_max, m_min
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, max_ab, c_exp, sign_max, eff_sub, shift,
           m_max, m_min
  );
endinterface

// File: rtl/fpaddsub_align_pipe.sv
// -----------------------------------------------------------------------------
// fpaddsub_align_pipe
// Two-stage alignment pipeline for the floating-point adder/subtractor.
// Stage 1 picks the larger-magnitude operand, swaps the significands and
// computes the exponent difference. Stage 2 right-shifts the smaller
// significand (with guard bits) and folds all shifted-out bits into a sticky
// bit at the LSB.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of fpaddsub_align_pipe_if (operand and result
//          valid/ready handshakes with full backpressure)
// -----------------------------------------------------------------------------
module fpaddsub_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRD_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  fpaddsub_align_pipe_if.slave   bus
);
  localparam int SW = MAN_W + 1 + GRD_W;
  localparam int DW = EXP_W + MAN_W + 1;
  localparam int FW = MAN_W + 1;

  // ---------------------------------------------------------------------------
  // Handshake: each stage may load when it is empty or its content is leaving.
  // ---------------------------------------------------------------------------
  logic v1_q, v1_d, v2_q, v2_d;
  logic en1, en2, ld1, ld2;

  assign en2 = !v2_q || bus.out_ready;
  assign en1 = !v1_q || en2;
  assign ld1 = en1 && bus.in_valid;
  assign ld2 = en2 && v1_q;
  assign v1_d = en1 ? bus.in_valid : v1_q;
  assign v2_d = en2 ? v1_q : v2_q;
  assign bus.in_ready = en1;

  // ---------------------------------------------------------------------------
  // Stage 1: compare, swap, exponent difference
  // ---------------------------------------------------------------------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [FW-1:0]    sig_a, sig_b;
  logic             b_larger;

  assign sign_a = bus.a[DW-1];
  assign sign_b = bus.b[DW-1];
  assign exp_a  = bus.a[DW-2 -: EXP_W];
  assign exp_b  = bus.b[DW-2 -: EXP_W];
  assign sig_a  = {exp_a != '0, bus.a[MAN_W-1:0]};
  assign sig_b  = {exp_b != '0, bus.b[MAN_W-1:0]};
  // Denormals share the scale of exponent 1.
  assign eexp_a = (exp_a == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_a;
  assign eexp_b = (exp_b == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_b;
  // {exp,frac} compares as an unsigned magnitude; ties keep A as the larger.
  assign b_larger = bus.a[DW-2:0] < bus.b[DW-2:0];

  logic             max_ab1_q, max_ab1_d;
  logic [EXP_W-1:0] c_exp1_q, c_exp1_d;
  logic             sign_max1_q, sign_max1_d;
  logic             eff_sub1_q, eff_sub1_d;
  logic [EXP_W-1:0] diff1_q, diff1_d;
  logic [FW-1:0]    sig_max1_q, sig_max1_d;
  logic [FW-1:0]    sig_min1_q, sig_min1_d;

  always_comb begin
    max_ab1_d   = b_larger;
    c_exp1_d    = b_larger ? exp_b : exp_a;
    sign_max1_d = b_larger ? (sign_b ^ bus.op) : sign_a;
    eff_sub1_d  = sign_a ^ sign_b ^ bus.op;
    // Non-negative by construction: the larger magnitude never has the
    // smaller effective exponent.
    diff1_d     = b_larger ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
    sig_max1_d  = b_larger ? sig_b : sig_a;
    sig_min1_d  = b_larger ? sig_a : sig_b;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturating right shift with sticky collection
  // ---------------------------------------------------------------------------
  logic [31:0]   shift_amt;
  logic [SW-1:0] full_min, shifted, lost_mask;
  logic          sticky;

  assign shift_amt = (32'(diff1_q) >= 32'(SW)) ? 32'(SW) : 32'(diff1_q);
  assign full_min  = {sig_min1_q, {GRD_W{1'b0}}};
  assign shifted   = full_min >> shift_amt;

  // Bit positions below the shift amount are the ones that fall off the end.
  for (genvar gi = 0; gi < SW; gi++) begin : g_lost_mask
    assign lost_mask[gi] = (32'(gi) < shift_amt);
  end

  assign sticky = |(full_min & lost_mask);

  logic             max_ab2_q, sign_max2_q, eff_sub2_q;
  logic [EXP_W-1:0] c_exp2_q, shift2_q, shift2_d;
  logic [SW-1:0]    m_max2_q, m_max2_d, m_min2_q, m_min2_d;

  assign shift2_d = shift_amt[EXP_W-1:0];
  assign m_max2_d = {sig_max1_q, {GRD_W{1'b0}}};
  assign m_min2_d = {shifted[SW-1:1], shifted[0] | sticky};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      max_ab1_q   <= 1'b0;
      c_exp1_q    <= '0;
      sign_max1_q <= 1'b0;
      eff_sub1_q  <= 1'b0;
      diff1_q     <= '0;
      sig_max1_q  <= '0;
      sig_min1_q  <= '0;
      max_ab2_q   <= 1'b0;
      c_exp2_q    <= '0;
      sign_max2_q <= 1'b0;
      eff_sub2_q  <= 1'b0;
      shift2_q    <= '0;
      m_max2_q    <= '0;
      m_min2_q    <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (ld1) begin
        max_ab1_q   <= max_ab1_d;
        c_exp1_q    <= c_exp1_d;
        sign_max1_q <= sign_max1_d;
        eff_sub1_q  <= eff_sub1_d;
        diff1_q     <= diff1_d;
        sig_max1_q  <= sig_max1_d;
        sig_min1_q  <= sig_min1_d;
      end
      if (ld2) begin
        max_ab2_q   <= max_ab1_q;
        c_exp2_q    <= c_exp1_q;
        sign_max2_q <= sign_max1_q;
        eff_sub2_q  <= eff_sub1_q;
        shift2_q    <= shift2_d;
        m_max2_q    <= m_max2_d;
        m_min2_q    <= m_min2_d;
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.max_ab    = max_ab2_q;
  assign bus.c_exp     = c_exp2_q;
  assign bus.sign_max  = sign_max2_q;
  assign bus.eff_sub   = eff_sub2_q;
  assign bus.shift     = shift2_q;
  assign bus.m_max     = m_max2_q;
  assign bus.m_min     = m_min2_q;
endmodule

// File: tb/tb_fpaddsub_align_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpaddsub_align_pipe
// Self-checking bench for fpaddsub_align_pipe at default parameters.
// -----------------------------------------------------------------------------
module tb_fpaddsub_align_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int GRD_W = 3;
  localparam int SW    = 27;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpaddsub_align_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) bus ();

  fpaddsub_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        max_ab;
    logic [7:0]  c_exp;
    logic        sign_max;
    logic        eff_sub;
    logic [7:0]  shift;
    logic [26:0] m_max;
    logic [26:0] m_min;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    res_t        exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  int   n_acc = 0;
  res_t q[$];

  // Reference: the IEEE alignment rule in plain integer arithmetic.
  function automatic res_t model(logic [31:0] a, logic [31:0] b, logic op);
    res_t        r;
    longint      ma, mb, sb, ss, lost;
    logic [31:0] big, sml;
    int          eb, es, d, sh;
    bit          bl;
    ma  = longint'(a[30:0]);
    mb  = longint'(b[30:0]);
    bl  = (ma < mb);
    big = bl ? b : a;
    sml = bl ? a : b;
    eb  = int'(big[30:23]);
    es  = int'(sml[30:23]);
    sb  = ((eb != 0) ? (longint'(1) << 23) : 0) + longint'(big[22:0]);
    ss  = ((es != 0) ? (longint'(1) << 23) : 0) + longint'(sml[22:0]);
    sb  = sb * 8;
    ss  = ss * 8;
    d   = ((eb == 0) ? 1 : eb) - ((es == 0) ? 1 : es);
    sh  = (d > SW) ? SW : d;
    lost = ss % (longint'(1) << sh);
    r.max_ab   = bl;
    r.c_exp    = 8'(eb);
    r.sign_max = bl ? (b[31] ^ op) : a[31];
    r.eff_sub  = a[31] ^ b[31] ^ op;
    r.shift    = 8'(sh);
    r.m_max    = 27'(sb);
    r.m_min    = 27'((ss >> sh) | ((lost != 0) ? 1 : 0));
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.max_ab   = bus.max_ab;
    r.c_exp    = bus.c_exp;
    r.sign_max = bus.sign_max;
    r.eff_sub  = bus.eff_sub;
    r.shift    = bus.shift;
    r.m_max    = bus.m_max;
    r.m_min    = bus.m_min;
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One clock of streaming traffic: observe at the falling edge, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got out_valid=1 required no pending result");
      end else begin
        check("stream_result", 128'(dut_res()), 128'(q[0]));
        if (bus.out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(model(bus.a, bus.b, bus.op));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_b(logic [31:0] a);
    logic [31:0] b;
    b = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: b[30:23] = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
      2: b[30:23] = a[30:23] - 8'($urandom_range(20, 40));
      default: b[30:23] = 8'($urandom_range(0, 1));
    endcase
    return b;
  endfunction

  vec_t vecs[7];

  task automatic run_vec(int i);
    int lat;
    bus.a        = vecs[i].a;
    bus.b        = vecs[i].b;
    bus.op       = vecs[i].op;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", i), 128'(lat), 128'(2));
    check($sformatf("vec%0d_result", i), 128'(dut_res()), 128'(vecs[i].exp));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_no_dup", i), 128'(bus.out_valid), 128'(0));
  endtask

  logic [31:0] bp_a[4];
  logic [31:0] bp_b[4];

  initial begin
    int idx, base_out, guard;

    //            a             b             op  max c_exp sgn eff sh  m_max         m_min
    vecs[0] = '{32'h3F800000, 32'h3F000000, 1'b0, '{1'b0, 8'h7F, 1'b0, 1'b0, 8'd1,  27'h4000000, 27'h2000000}};
    vecs[1] = '{32'h3F800000, 32'h30800000, 1'b0, '{1'b0, 8'h7F, 1'b0, 1'b0, 8'd27, 27'h4000000, 27'h0000001}};
    vecs[2] = '{32'h00000001, 32'h00800000, 1'b0, '{1'b1, 8'h01, 1'b0, 1'b0, 8'd0,  27'h4000000, 27'h0000008}};
    vecs[3] = '{32'h3F800000, 32'h3F800000, 1'b1, '{1'b0, 8'h7F, 1'b0, 1'b1, 8'd0,  27'h4000000, 27'h4000000}};
    vecs[4] = '{32'h00000000, 32'h00000000, 1'b0, '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0,  27'h0000000, 27'h0000000}};
    vecs[5] = '{32'hBF800000, 32'h40000000, 1'b1, '{1'b1, 8'h80, 1'b1, 1'b0, 8'd1,  27'h4000000, 27'h2000000}};
    vecs[6] = '{32'h3F800000, 32'h3C800001, 1'b0, '{1'b0, 8'h7F, 1'b0, 1'b0, 8'd6,  27'h4000000, 27'h0100001}};

    bp_a[0] = 32'h3F800000; bp_b[0] = 32'h3E800000;
    bp_a[1] = 32'h41200000; bp_b[1] = 32'hC0A00000;
    bp_a[2] = 32'h00400000; bp_b[2] = 32'h00800001;
    bp_a[3] = 32'h7F7FFFFF; bp_b[3] = 32'h3F800000;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_data", 128'(dut_res()), 128'(0));

    // Directed vectors from the table.
    for (int i = 0; i < 7; i++) run_vec(i);

    // Backpressure: offer 4 pairs with the output blocked.
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.a = bp_a[idx];
      bus.b = bp_b[idx];
      bus.op = 1'(idx);
      base_out = n_acc;
      step();
      if (n_acc != base_out) idx++;
    end
    check("bp_accepted", 128'(idx), 128'(2));
    @(negedge clk);
    check("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    base_out = n_out;
    guard = 0;
    while ((idx < 4 || q.size() != 0) && guard < 30) begin
      bus.in_valid = (idx < 4);
      if (idx < 4) begin
        bus.a = bp_a[idx];
        bus.b = bp_b[idx];
        bus.op = 1'(idx);
      end
      base_out = base_out;
      begin
        int acc_before;
        acc_before = n_acc;
        step();
        if (n_acc != acc_before) idx++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    check("bp_all_out", 128'(n_out - base_out), 128'(4));

    // Randomized streaming with random stalls on both sides.
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a = $urandom;
      bus.b = rand_b(bus.a);
      bus.op = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    check("random_drained", 128'(q.size()), 128'(0));

    // Reset with both stages holding data.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 32'h40490FDB;
    bus.b = 32'h3DCCCCCD;
    step();
    bus.a = 32'hC2C80000;
    step();
    bus.in_valid = 1'b0;
    step();
    check("pre_reset_full", 128'(q.size()), 128'(2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("mid_reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_reset_data", 128'(dut_res()), 128'(0));
    check("mid_reset_in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    base_out = n_out;
    repeat (6) step();
    check("no_stale_after_reset", 128'(n_out - base_out), 128'(0));
    bus.in_valid = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h3F000000;
    bus.op = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    check("post_reset_one_out", 128'(n_out - base_out), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpaddsub_align_pipe.md
Name: fpaddsub_align_pipe

Overview:
Pipelined, parametrised alignment stage for the floating-point adder/subtractor. It takes two IEEE-style operands and an add/sub opcode, selects the larger magnitude, computes the exponent difference internally, and right-shifts the smaller significand with guard bits and a sticky bit. Operands enter and results leave through valid/ready handshakes with full backpressure. It sits between operand input registering and the significand adder.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)
GRD_W, 3, extra low-order bits appended below the fraction (guard/round/sticky); must be >=2
Derived: SW = MAN_W+1+GRD_W, the significand output width (27 at defaults); DW = EXP_W+MAN_W+1, the operand width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  DW  operand A {sign, exp, frac}
b  in  DW  operand B
op  in  1  0 = A+B, 1 = A-B (B sign inverted)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
max_ab  out  1  0 = A larger or equal magnitude, 1 = B larger
c_exp  out  EXP_W  common exponent (exponent of larger operand)
sign_max  out  1  effective sign of larger operand (B sign inverted when op=1)
eff_sub  out  1  effective operation is subtraction: sign(A) XOR sign(B) XOR op
shift  out  EXP_W  applied shift, saturated to SW
m_max  out  SW  {hidden, frac, GRD_W zeros} of larger operand
m_min  out  SW  aligned smaller significand; LSB is ORed with sticky

Behaviour:
- Reset (rst=1 at a clock edge): all valid flags clear. Every data output register goes to 0: max_ab, c_exp, sign_max, eff_sub, shift, m_max and m_min. in_ready=1 in the cycle after reset. Reset mid-operation discards in-flight operands with no output.
- Fixed latency of 2 cycles when there is no backpressure. Throughput is 1 operand pair per cycle.
- Stage 1 (registered):
  - Magnitude compare on {exp,frac}. Strict less-than gives max_ab=1. Equal magnitudes give max_ab=0.
  - Hidden bit = (exp != 0).
  - Effective exponent = 1 when exp==0 (denormal), otherwise exp.
  - Raw diff = eff_exp(max) - eff_exp(min), computed unsigned; it is never negative by construction.
  - Significands are swapped here. c_exp = raw exp field of the larger operand.
  - sign_max and eff_sub are also computed in this stage.
- Stage 2 (registered):
  - shift = min(diff, SW).
  - m_min = ({hidden,frac,0s} >> shift), with bit 0 ORed with the OR-reduction of all bits shifted out.
  - When shift==SW, m_min = {0..0, sticky}, so it is 1 if the smaller operand is nonzero and 0 otherwise.
  - m_max passes through unchanged.
- Handshake:
  - A transfer occurs on valid&&ready.
  - stage2 enable = !v2 || out_ready. stage1 enable = !v1 || stage2 enable. in_ready = stage1 enable (combinational).
  - Output registers hold stable while out_valid && !out_ready.
  - in_valid=0 with in_ready=1 creates a bubble; data registers may update or hold, but valids are exact.
- Simultaneous accept at input and output in the same cycle is allowed. No data loss or duplication.
- Infinities and NaNs are not decoded here. They are treated as large finite values; the downstream special-case logic handles them.

Test Plan:
- A=0x3F800000 (1.0), B=0x3F000000 (0.5), op=0, out_ready=1 -> 2 cycles later: max_ab=0, c_exp=0x7F, shift=1, m_max=0x4000000, m_min=0x2000000, eff_sub=0.
- A=0x3F800000, B=0x30800000 (2^-30) -> shift=27 (saturated), m_min=0x0000001 (sticky only), m_max=0x4000000.
- A=0x00000001, B=0x00800000 -> max_ab=1, c_exp=0x01, shift=0, m_max=0x4000000, m_min=0x0000008.
- A=B=0x3F800000, op=1 -> max_ab=0 (tie), eff_sub=1, sign_max=0, shift=0, m_min=m_max=0x4000000.
- Backpressure: hold out_ready=0 and offer 4 back-to-back pairs -> exactly 2 are accepted, then in_ready=0 and outputs stay stable. Release out_ready -> all 4 results emerge in order, none lost or duplicated.
- Assert rst for one cycle while both stages are valid -> next cycle out_valid=0, all data outputs 0, in_ready=1. No stale result appears afterwards.
